frame_sync_deser: RTL and testbench

- Sits directly downstream of the CDR and consumes its sample_en strobe and d_bb hard decision.
- Finds a fixed 16-bit sync word in the recovered bit stream.
- Confirms alignment over several frames with a SEARCH/VERIFY/LOCKED state machine, using hysteresis (flywheel) on loss.
- Once locked, deserializes the payload MSB-first into bytes with start/end-of-frame markers and error/frame statistics.

---
 rtl/cdr_pkg.sv | 22 ++
 rtl/bit_deser8.sv | 41 ++++
 rtl/frame_sync_deser.sv | 145 ++++++++++++++
 tb/tb_frame_sync_deser.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
// Shared types and constants for the frame synchroniser / deserializer slice.
package cdr_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } fs_state_e;

  localparam int unsigned     SYNC_W_DEF    = 16;
  localparam logic [15:0]     SYNC_WORD_DEF = 16'hF628;
  localparam int unsigned     BYTE_W        = 8;
  localparam int unsigned     STAT_W        = 8;
  localparam int unsigned     FRAME_CNT_W   = 16;

  // Frame length in bits: sync word plus payload bytes.
  function automatic int unsigned frame_len(input int unsigned sync_w,
                                            input int unsigned payload_bytes);
    return sync_w + BYTE_W * payload_bytes;
  endfunction

endpackage

// File: rtl/bit_deser8.sv
// Serial-to-byte shifter: MSB-first, registered byte and one-cycle done pulse.
module bit_deser8
  import cdr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din,
  input  logic              clear,
  output logic [BYTE_W-1:0] data,
  output logic              done
);

  localparam int unsigned IDX_W = 3;

  logic [IDX_W-1:0]  idx_q;
  logic [BYTE_W-2:0] sh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      sh_q  <= '0;
      data  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        idx_q <= '0;
      end else if (en) begin
        sh_q  <= {sh_q[BYTE_W-3:0], din};
        idx_q <= idx_q + 1'b1;
        // Eighth bit completes the byte; publish it together with the pulse.
        if (idx_q == IDX_W'(BYTE_W - 1)) begin
          data <= {sh_q, din};
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/frame_sync_deser.sv
// Sync-word search/verify/lock controller with flywheel loss and payload deserialization.
module frame_sync_deser
  import cdr_pkg::*;
#(
  parameter int unsigned       SYNC_W        = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_WORD     = SYNC_W'(SYNC_WORD_DEF),
  parameter int unsigned       PAYLOAD_BYTES = 8,
  parameter int unsigned       VERIFY_CNT    = 2,
  parameter int unsigned       LOSS_CNT      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  input  logic                   d_bb,
  output logic [BYTE_W-1:0]      byte_data,
  output logic                   byte_valid,
  output logic                   sof,
  output logic                   eof,
  output logic                   locked,
  output logic [1:0]             state,
  output logic [STAT_W-1:0]      sync_err_cnt,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned L        = frame_len(SYNC_W, PAYLOAD_BYTES);
  localparam int unsigned PAY_BITS = BYTE_W * PAYLOAD_BYTES;
  localparam int unsigned CNT_W    = $clog2(L);
  localparam int unsigned GOOD_W   = $clog2(VERIFY_CNT + 1);
  localparam int unsigned MISS_W   = $clog2(LOSS_CNT + 1);

  fs_state_e              state_q, state_d;
  logic [SYNC_W-1:0]      sr_q, sr_d, nsr;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic [MISS_W-1:0]      miss_q, miss_d;
  logic [STAT_W-1:0]      err_q, err_d;
  logic [FRAME_CNT_W-1:0] frm_q, frm_d;
  logic                   locked_q, locked_d;
  logic                   sof_q, eof_q;
  logic                   match, at_check, deser_en, deser_clear;

  assign nsr         = {sr_q[SYNC_W-2:0], d_bb};
  assign match       = (nsr == SYNC_WORD);
  assign at_check    = (cnt_q == CNT_W'(L - 1));
  assign deser_en    = sample_en && (state_q == ST_LOCKED) && (cnt_q < CNT_W'(PAY_BITS));
  assign deser_clear = (state_q != ST_LOCKED);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      sr_q     <= '0;
      cnt_q    <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      err_q    <= '0;
      frm_q    <= '0;
      locked_q <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      frm_q    <= frm_d;
      locked_q <= locked_d;
      sof_q    <= deser_en && (cnt_q == CNT_W'(BYTE_W - 1));
      eof_q    <= deser_en && (cnt_q == CNT_W'(PAY_BITS - 1));
    end
  end

  // Next-state logic; everything holds on cycles without a symbol strobe.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    miss_d  = miss_q;
    err_d   = err_q;
    frm_d   = frm_q;
    if (sample_en) begin
      sr_d = nsr;
      unique case (state_q)
        ST_SEARCH: begin
          if (match) begin
            state_d = ST_VERIFY;
            cnt_d   = '0;
            good_d  = '0;
          end
        end
        ST_VERIFY: begin
          cnt_d = at_check ? '0 : cnt_q + 1'b1;
          if (at_check) begin
            if (match) begin
              good_d = good_q + 1'b1;
              if (good_d == GOOD_W'(VERIFY_CNT)) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
              end
            end else begin
              state_d = ST_SEARCH;
            end
          end
        end
        ST_LOCKED: begin
          cnt_d = at_check ? '0 : cnt_q + 1'b1;
          if (at_check) begin
            if (match) begin
              miss_d = '0;
              frm_d  = frm_q + 1'b1;
            end else begin
              // Flywheel: tolerate isolated misses, drop only on a run of them.
              if (err_q != '1) err_d = err_q + 1'b1;
              miss_d = miss_q + 1'b1;
              if (miss_d == MISS_W'(LOSS_CNT)) state_d = ST_SEARCH;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  bit_deser8 u_deser (
    .clk   (clk),
    .rst   (rst),
    .en    (deser_en),
    .din   (d_bb),
    .clear (deser_clear),
    .data  (byte_data),
    .done  (byte_valid)
  );

  assign sof          = sof_q;
  assign eof          = eof_q;
  assign locked       = locked_q;
  assign state        = state_q;
  assign sync_err_cnt = err_q;
  assign frame_cnt    = frm_q;

endmodule

// File: tb/tb_frame_sync_deser.sv
// Directed-sequence bench with randomized payloads checked against a bit-history reference model.
module tb_frame_sync_deser;

  localparam int          L        = 80;
  localparam int          PAY_BITS = 64;
  localparam int          VCNT     = 2;
  localparam int          LCNT     = 3;
  localparam logic [15:0] SYNC     = 16'hF628;

  logic        clk = 1'b0;
  logic        rst, sample_en, d_bb;
  logic [7:0]  byte_data;
  logic        byte_valid, sof, eof, locked;
  logic [1:0]  state;
  logic [7:0]  sync_err_cnt;
  logic [15:0] frame_cnt;

  logic        se2, d2;
  logic [7:0]  s_byte;
  logic        s_valid, s_sof, s_eof, s_locked;
  logic [1:0]  s_state;
  logic [7:0]  s_err;
  logic [15:0] s_frames;

  always #5 clk = ~clk;

  frame_sync_deser u_dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .d_bb(d_bb),
    .byte_data(byte_data), .byte_valid(byte_valid), .sof(sof), .eof(eof),
    .locked(locked), .state(state), .sync_err_cnt(sync_err_cnt), .frame_cnt(frame_cnt)
  );

  frame_sync_deser #(.LOSS_CNT(400)) u_sat (
    .clk(clk), .rst(rst), .sample_en(se2), .d_bb(d2),
    .byte_data(s_byte), .byte_valid(s_valid), .sof(s_sof), .eof(s_eof),
    .locked(s_locked), .state(s_state), .sync_err_cnt(s_err), .frame_cnt(s_frames)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int dut_bytes = 0;
  logic [7:0] first_data;
  logic       first_sof;

  // Reference model: state as small ints, bytes and sync matches read off the bit history.
  int   m_st, m_good, m_miss, m_errs, m_frames, m_k, m_anchor;
  logic [7:0] m_data;
  logic m_valid, m_sof, m_eof;
  bit   hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] last16();
    logic [15:0] w = '0;
    int sz = hist.size();
    for (int i = 0; i < 16; i++) w = {w[14:0], hist[sz-16+i]};
    return w;
  endfunction

  function automatic logic [7:0] last8();
    logic [7:0] w = '0;
    int sz = hist.size();
    for (int i = 0; i < 8; i++) w = {w[6:0], hist[sz-8+i]};
    return w;
  endfunction

  task automatic model_reset();
    m_st = 0; m_good = 0; m_miss = 0; m_errs = 0; m_frames = 0;
    m_k = 0; m_anchor = 0; m_data = '0;
    m_valid = 1'b0; m_sof = 1'b0; m_eof = 1'b0;
    hist.delete();
    repeat (16) hist.push_back(1'b0);
  endtask

  task automatic model_step(input logic b);
    int   off;
    logic hit;
    hist.push_back(b);
    if (hist.size() > 32) void'(hist.pop_front());
    m_valid = 1'b0; m_sof = 1'b0; m_eof = 1'b0;
    hit = (last16() == SYNC);
    if (m_st == 0) begin
      if (hit) begin m_st = 1; m_anchor = m_k; m_good = 0; end
    end else begin
      off = m_k - m_anchor;
      if (m_st == 2 && off <= PAY_BITS && off % 8 == 0) begin
        m_valid = 1'b1;
        m_data  = last8();
        m_sof   = (off == 8);
        m_eof   = (off == PAY_BITS);
      end
      if (off == L) begin
        m_anchor = m_k;
        if (m_st == 1) begin
          if (hit) begin
            m_good++;
            if (m_good == VCNT) begin m_st = 2; m_miss = 0; end
          end else m_st = 0;
        end else begin
          if (hit) begin
            m_miss = 0;
            m_frames = (m_frames + 1) % 65536;
          end else begin
            if (m_errs < 255) m_errs++;
            m_miss++;
            if (m_miss == LCNT) m_st = 0;
          end
        end
      end
    end
    m_k++;
  endtask

  task automatic check_all();
    if (byte_valid === 1'b1) begin
      if (dut_bytes == 0) begin first_data = byte_data; first_sof = sof; end
      dut_bytes++;
    end
    chk("byte_valid", byte_valid, m_valid);
    chk("sof", sof, m_sof);
    chk("eof", eof, m_eof);
    chk("byte_data", byte_data, m_data);
    chk("locked", locked, (m_st == 2));
    chk("state", state, m_st);
    chk("sync_err_cnt", sync_err_cnt, m_errs);
    chk("frame_cnt", frame_cnt, m_frames);
  endtask

  task automatic send_bit(input logic b, input int gap);
    sample_en = 1'b1;
    d_bb      = b;
    @(posedge clk); #1;
    sample_en = 1'b0;
    d_bb      = 1'($urandom);
    model_step(b);
    check_all();
    repeat (gap) begin
      @(posedge clk); #1;
      m_valid = 1'b0; m_sof = 1'b0; m_eof = 1'b0;
      check_all();
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i], 1);
  endtask

  task automatic send_payload(input logic [63:0] p, input int stall_at);
    for (int i = 63; i >= 0; i--) send_bit(p[i], ((63 - i) == stall_at) ? 10 : 1);
  endtask

  function automatic logic [63:0] ramp(input logic [7:0] k);
    logic [63:0] p = '0;
    for (int i = 0; i < 8; i++) p = {p[55:0], 8'(k + 8'(i))};
    return p;
  endfunction

  function automatic logic [63:0] rand_payload();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [15:0] bad_sync();
    return SYNC ^ (16'(1) << $urandom_range(15, 0));
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    sample_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic sat_bit(input logic b);
    d2 = b;
    @(posedge clk); #1;
  endtask

  task automatic sat_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) sat_bit(w[i]);
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; sample_en = 1'b0; d_bb = 1'b0; se2 = 1'b0; d2 = 1'b0;
    model_reset();

    // Clean stream: detect, two confirmations, then payload with markers
    do_reset();
    chk("reset_locked", locked, 0);
    chk("reset_byte_valid", byte_valid, 0);
    repeat (8) send_bit(1'($urandom), 1);
    send_word(SYNC);
    chk("p1_state_sync1", state, 1);
    send_payload(ramp(8'h10), -1);
    send_word(SYNC);
    chk("p1_state_sync2", state, 1);
    send_payload(ramp(8'h20), -1);
    send_word(SYNC);
    chk("p1_locked_sync3", locked, 1);
    chk("p1_state_sync3", state, 2);
    dut_bytes = 0;
    send_payload(ramp(8'h30), -1);
    chk("p1_bytes_frame", dut_bytes, 8);
    chk("p1_first_byte", first_data, 8'h30);
    chk("p1_first_sof", first_sof, 1);
    send_word(SYNC);
    chk("p1_frame_cnt1", frame_cnt, 1);
    send_payload(ramp(8'h40), -1);
    send_word(SYNC);
    chk("p1_frame_cnt2", frame_cnt, 2);

    // False sync inside random data, then a genuine stream
    do_reset();
    dut_bytes = 0;
    repeat (8) send_bit(1'($urandom), 1);
    send_word(SYNC);
    chk("p2_false_verify", state, 1);
    send_payload(rand_payload(), -1);
    w = 16'($urandom);
    if (w == SYNC) w = w ^ 16'h0001;
    send_word(w);
    chk("p2_false_drop", state, 0);
    chk("p2_no_bytes", dut_bytes, 0);
    send_word(SYNC);
    send_payload(rand_payload(), -1);
    send_word(SYNC);
    send_payload(rand_payload(), -1);
    send_word(SYNC);
    chk("p2_relock", locked, 1);

    // Flywheel: isolated misses tolerated, three in a row drop lock
    send_payload(rand_payload(), -1); send_word(SYNC);
    send_payload(rand_payload(), -1); send_word(bad_sync());
    send_payload(rand_payload(), -1); send_word(SYNC);
    send_payload(rand_payload(), -1); send_word(bad_sync());
    send_payload(rand_payload(), -1); send_word(SYNC);
    chk("p3_flywheel_locked", locked, 1);
    chk("p3_flywheel_err", sync_err_cnt, 2);
    for (int n = 1; n <= 3; n++) begin
      send_payload(rand_payload(), -1);
      send_word(bad_sync());
      chk("p3_loss_locked", locked, (n < 3) ? 1 : 0);
    end
    chk("p3_loss_state", state, 0);
    chk("p3_loss_err", sync_err_cnt, 5);
    repeat (16) send_bit(1'b0, 1);
    send_word(SYNC);
    send_payload(rand_payload(), -1); send_word(SYNC);
    send_payload(rand_payload(), -1); send_word(SYNC);
    chk("p3_relock", locked, 1);

    // Stall mid-byte: outputs hold, no bits lost or repeated
    dut_bytes = 0;
    send_payload(rand_payload(), 13);
    chk("p4_bytes_after_stall", dut_bytes, 8);
    send_word(SYNC);
    send_payload(rand_payload(), 42);
    send_word(SYNC);
    chk("p4_still_locked", locked, 1);

    // Reset mid-frame while locked, then full relock sequence
    for (int i = 0; i < 30; i++) send_bit(1'($urandom), 1);
    do_reset();
    chk("p5_locked", locked, 0);
    chk("p5_err", sync_err_cnt, 0);
    chk("p5_frames", frame_cnt, 0);
    chk("p5_byte_data", byte_data, 0);
    send_word(SYNC);
    chk("p5_verify", state, 1);
    send_payload(rand_payload(), -1); send_word(SYNC);
    chk("p5_not_yet_locked", locked, 0);
    send_payload(rand_payload(), -1); send_word(SYNC);
    chk("p5_relocked", locked, 1);
    send_payload(rand_payload(), -1); send_word(SYNC);

    // Saturation on the high-tolerance instance at one symbol per clock
    se2 = 1'b1;
    sat_word(SYNC);
    repeat (64) sat_bit(1'b0);
    sat_word(SYNC);
    repeat (64) sat_bit(1'b0);
    sat_word(SYNC);
    chk("sat_locked", s_locked, 1);
    for (int n = 1; n <= 300; n++) begin
      repeat (64) sat_bit(1'b0);
      sat_word(SYNC ^ 16'h0001);
      chk("sat_err_cnt", s_err, (n < 255) ? n : 255);
    end
    chk("sat_locked_end", s_locked, 1);
    chk("sat_state_end", s_state, 2);
    se2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
